// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard front end: synchronises and filters the PS/2 pins, deserialises
// 11-bit frames, checks parity/stop, and reports each key make code as a single
// strobe. Break sequences (F0 xx) and extended prefixes (E0) are swallowed.
module ps2_key_receiver #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_key_code,
    output logic       o_key_on,
    output logic       o_key_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_CHECK
    } state_t;

    logic          r_clk_s1, r_clk_s2;
    logic          r_dat_s1, r_dat_s2;
    logic [FW-1:0] r_fcnt;
    logic          r_filt;
    logic          r_fall;

    state_t        r_state;
    logic [9:0]    r_shift;
    logic [3:0]    r_bcnt;
    logic [WW-1:0] r_wdog;
    logic          r_brk;
    logic          r_ext;

    logic [7:0]    w_byte;
    logic          w_par_ok;
    logic          w_stop_ok;

    // shift register holds d0..d7 in [7:0], parity in [8], stop in [9]
    assign w_byte    = r_shift[7:0];
    assign w_par_ok  = ^r_shift[8:0];
    assign w_stop_ok = r_shift[9];

    // 2-FF synchronisers for both pins; idle bus level is 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // ps2_clk glitch filter: level flips after FILTER_LEN consecutive opposite
    // samples; r_fall strobes for one cycle on a filtered 1->0 flip
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt <= '0;
            r_filt <= 1'b1;
            r_fall <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (r_clk_s2 == r_filt) begin
                r_fcnt <= '0;
            end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
                r_fcnt <= '0;
                r_filt <= r_clk_s2;
                r_fall <= r_filt;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    // frame FSM: receive, watchdog, check and decode with registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bcnt     <= '0;
            r_wdog     <= '0;
            r_brk      <= 1'b0;
            r_ext      <= 1'b0;
            o_key_code <= 8'h00;
            o_key_on   <= 1'b0;
            o_key_err  <= 1'b0;
        end else begin
            o_key_on  <= 1'b0;
            o_key_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_wdog <= '0;
                    // a high sample on a fall is line noise, not a start bit
                    if (r_fall && !r_dat_s2) begin
                        r_state <= S_RECV;
                        r_bcnt  <= 4'd1;
                    end
                end
                S_RECV: begin
                    if (r_fall) begin
                        r_shift <= {r_dat_s2, r_shift[9:1]};
                        r_bcnt  <= r_bcnt + 4'd1;
                        r_wdog  <= '0;
                        if (r_bcnt == 4'd10)
                            r_state <= S_CHECK;
                    end else if (r_wdog == WW'(TIMEOUT_CYC - 1)) begin
                        r_state   <= S_IDLE;
                        r_bcnt    <= '0;
                        r_wdog    <= '0;
                        o_key_err <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                S_CHECK: begin
                    r_state <= S_IDLE;
                    r_bcnt  <= '0;
                    r_wdog  <= '0;
                    if (!w_par_ok || !w_stop_ok) begin
                        o_key_err <= 1'b1;
                    end else if (w_byte == 8'hF0) begin
                        r_brk <= 1'b1;
                    end else if (w_byte == 8'hE0) begin
                        r_ext <= 1'b1;
                    end else if (r_brk) begin
                        // second byte of a release: drop it and reset the prefix state
                        r_brk <= 1'b0;
                        r_ext <= 1'b0;
                    end else begin
                        o_key_code <= w_byte;
                        o_key_on   <= 1'b1;
                        r_ext      <= r_ext & 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ps2_key_receiver.md
# ps2_key_receiver

- Front-end stage of the parking controller.
- Deserialises PS/2 keyboard frames from the external `ps2_clk`/`ps2_data` pins and validates them.
- Presents each key make code as `key_code` with a one-cycle `key_on` strobe. These drive the controller's `key1_code`/`key1_on` inputs.
- Swallows break (release) sequences and extended prefixes, so each physical key press yields exactly one strobe.

## Interface
- `FILTER_LEN`, default 8: consecutive identical `clk` samples required before the filtered `ps2_clk` level changes.
- `TIMEOUT_CYC`, default 50000: `clk` cycles without a filtered falling edge, mid-frame, before the frame is aborted.
- `clk`  in  1: system clock. All logic is on its rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `ps2_clk`  in  1: raw PS/2 clock from the keyboard, asynchronous.
- `ps2_data`  in  1: raw PS/2 data, asynchronous.
- `key_code`  out  8: last accepted make code. Holds its value between strobes.
- `key_on`  out  1: one-cycle strobe; `key_code` is valid in the same cycle.
- `key_err`  out  1: one-cycle strobe on a framing, parity or timeout error.

## Operation
- **Reset values:** `key_code`=0x00, `key_on`=0, `key_err`=0. The FSM is in IDLE, the bit counter is 0, and the break and extended flags are clear. The synchroniser and filter registers reset to 1 (bus idle).
- **Input conditioning:**
  - Each of `ps2_clk` and `ps2_data` passes through a 2-FF synchroniser.
  - The synchronised `ps2_clk` feeds a saturating counter filter. The filtered level flips only after `FILTER_LEN` consecutive samples of the opposite value.
  - `fall` is a one-cycle strobe generated on a filtered 1→0 transition.
  - On `fall`, the synchronised `ps2_data` is the sampled bit.
- **Frame format:** 11 bits, LSB first: start(0), d0..d7, odd parity, stop(1).
- **FSM states:**
  - IDLE: on `fall` with sampled bit 0, go to RECV with count=1. On `fall` with sampled bit 1, stay in IDLE and raise no error (noise).
  - RECV:
    - Each `fall` shifts the sampled bit into a 10-bit register and increments count.
    - When count reaches 11 (stop bit sampled), go to CHECK.
    - A watchdog reloads on every `fall`. If it reaches `TIMEOUT_CYC`, go to IDLE and pulse `key_err`.
  - CHECK (one cycle): parity is correct when d0..d7 plus the parity bit has an odd number of ones, and the stop bit must be 1.
    - Failure: pulse `key_err`, go to IDLE. `key_code`, the break flag and the extended flag are unchanged.
    - Success: decode the byte (below), go to IDLE.
- **Decode of a valid byte:**
  - 0xF0: set the break flag, no output.
  - 0xE0: set the extended flag, no output.
  - Any other byte with the break flag set: clear both flags, no output (release of that key).
  - Any other byte with the break flag clear: load `key_code`, pulse `key_on`, clear the extended flag. An extended make is therefore reported by its second byte only.
- **Keyboard auto-repeat:** repeated make codes each produce a `key_on`.

## Timing
- `fall` lags the raw `ps2_clk` falling edge by 2 + `FILTER_LEN` cycles.
- CHECK is the cycle after the stop-bit `fall`.
- `key_on` and `key_err` are registered, high in the cycle after CHECK, for exactly one cycle. Latency from stop-bit `fall` to strobe is 2 cycles.
- `key_code` updates in the same cycle `key_on` rises. It never changes without `key_on`.
- `key_on` and `key_err` are never high together.
- Watchdog is active only in RECV. In IDLE the counter is held at 0.
- Asynchronous `rst_n` assertion mid-frame discards the partial frame and the flags immediately. Strobes drop in the same instant.
- After `rst_n` deassertion, the first valid frame is accepted normally.
- A `fall` arriving in the CHECK cycle is impossible at legal PS/2 rates (≥60 µs bit period). It requires no handling beyond being ignored.
- `clk` must be at least 20× the PS/2 clock rate for the filter to pass real edges.

## Test plan
- Make 0x16, correct parity (0), stop 1 → `key_code`=0x16. `key_on` high one cycle, 2 cycles after the stop `fall`. `key_err` stays 0.
- Sequence 0x26, 0xF0, 0x26 → one `key_on` with `key_code`=0x26. No strobe for the F0/26 pair. Break flag clear afterwards.
- 0xE0, 0x75 → single `key_on` with `key_code`=0x75. No strobe for 0xE0.
- 0x76 with parity bit inverted → `key_err` one-cycle pulse, no `key_on`, `key_code` keeps its previous value. A following good 0x76 → `key_on` with 0x76.
- Five bits of a frame, then `ps2_clk` held high for `TIMEOUT_CYC`+5 cycles → exactly one `key_err`, FSM in IDLE. A full 0x16 frame then yields `key_on` with 0x16.
- Glitches and reset:
  - `ps2_clk` low glitch of `FILTER_LEN`-1 cycles during IDLE → no `fall` and no state change.
  - `rst_n` pulsed low after bit 4 of a frame → outputs return to 0 immediately. The next complete 0x16 frame is accepted.
